// File: rtl/memlcd_pkg.sv
// Shared definitions for the memory-LCD frame writer.
// Holds the default frame geometry, the i_mode encodings, the writer FSM
// state encoding and the colour-bar palette.
package memlcd_pkg;

  localparam int DEF_H_WORDS = 120;
  localparam int DEF_V_LINES = 640;

  typedef enum logic [1:0] {
    MODE_STREAM = 2'b00,
    MODE_BARS   = 2'b01,
    MODE_CHECK  = 2'b10,
    MODE_SOLID  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STREAM  = 2'd1,
    ST_PAD     = 2'd2,
    ST_PATTERN = 2'd3
  } state_e;

  // Eight vertical bars, RGB 2:2:2.
  function automatic logic [5:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return 6'h00;
      3'd1:    return 6'h03;
      3'd2:    return 6'h0C;
      3'd3:    return 6'h0F;
      3'd4:    return 6'h30;
      3'd5:    return 6'h33;
      3'd6:    return 6'h3C;
      default: return 6'h3F;
    endcase
  endfunction

endpackage

// File: rtl/memlcd_frame_writer_if.sv
// Host pixel stream into the frame writer.
//   i_s_valid : host word valid
//   i_s_data  : RGB 2:2:2 pixel
//   i_s_sof   : word is pixel (0,0) of a frame
//   o_s_ready : word accepted when valid && ready
// master = host side, slave = frame writer side.
interface memlcd_stream_if;
  logic       i_s_valid;
  logic [5:0] i_s_data;
  logic       i_s_sof;
  logic       o_s_ready;

  modport master (output i_s_valid, output i_s_data, output i_s_sof, input o_s_ready);
  modport slave  (input i_s_valid, input i_s_data, input i_s_sof, output o_s_ready);
endinterface

// File: rtl/memlcd_pattern_gen.sv
// Combinational bring-up pattern source.
//   mode : latched pattern mode (bars / checkerboard / solid)
//   col  : column of the word being generated
//   row  : row of the word being generated
//   pix  : 6-bit RGB 2:2:2 pixel
module memlcd_pattern_gen
  import memlcd_pkg::*;
#(
  parameter int CW = 7,
  parameter int RW = 10
) (
  input  mode_e         mode,
  input  logic [CW-1:0] col,
  input  logic [RW-1:0] row,
  output logic [5:0]    pix
);

  logic [2:0] bar_idx;
  logic       chk_on;

  always_comb begin
    // col/15 as a threshold search, avoiding a divider.
    bar_idx = 3'd0;
    for (int b = 1; b < 8; b++) begin
      if (32'(col) >= 32'(15 * b)) bar_idx = 3'(b);
    end
    chk_on = ((col & CW'(8)) != '0) ^ ((row & RW'(8)) != '0);
    case (mode)
      MODE_BARS:  pix = bar_color(bar_idx);
      MODE_CHECK: pix = chk_on ? 6'h3F : 6'h00;
      default:    pix = 6'h00;
    endcase
  end

endmodule

// File: rtl/memlcd_frame_writer.sv
// Write-side producer for the memory-LCD pixel FIFO. Emits exactly
// H_WORDS x V_LINES words per frame, either from the host stream (aligned
// on SOF, padded with zeros after an early SOF) or from a test pattern.
//   i_clk, i_reset : FIFO write clock, async active-high reset
//   i_mode         : 00 stream, 01 bars, 10 checkerboard, 11 black
//   s_if           : host pixel stream (slave)
//   o_winc/o_wdata : FIFO write port, i_wfull its full flag
//   o_frame_done   : pulse with the last write of a frame
//   o_err_early    : pulse when SOF arrives mid-frame
//   o_err_drop     : pulse per non-SOF word discarded while waiting for SOF
module memlcd_frame_writer
  import memlcd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int H_WORDS    = DEF_H_WORDS,
  parameter int V_LINES    = DEF_V_LINES
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [1:0]            i_mode,
  memlcd_stream_if.slave        s_if,
  output logic                  o_winc,
  output logic [DATA_WIDTH-1:0] o_wdata,
  input  logic                  i_wfull,
  output logic                  o_frame_done,
  output logic                  o_err_early,
  output logic                  o_err_drop
);

  localparam int CW = (H_WORDS > 1) ? $clog2(H_WORDS) : 1;
  localparam int RW = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(H_WORDS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(V_LINES - 1);

  state_e        state;
  mode_e         r_mode;
  mode_e         mode_in;
  logic [CW-1:0] col, nxt_col, ld_col;
  logic [RW-1:0] row, nxt_row, ld_row;
  logic          r_vld;
  logic [5:0]    r_data;
  logic          can_load, ld_last, ready, host_acc, early_sof;
  logic          load_en;
  logic [5:0]    load_data, pat_pix;

  assign mode_in = mode_e'(i_mode);

  assign o_winc       = r_vld && !i_wfull;
  assign o_wdata      = DATA_WIDTH'(r_data);
  assign o_frame_done = o_winc && (col == COL_LAST) && (row == ROW_LAST);
  assign can_load     = !r_vld || o_winc;

  // col/row count written words; the word loaded this cycle sits one
  // position ahead whenever the output register is occupied.
  always_comb begin
    nxt_col = col + 1'b1;
    nxt_row = row;
    if (col == COL_LAST) begin
      nxt_col = '0;
      nxt_row = (row == ROW_LAST) ? '0 : row + 1'b1;
    end
  end

  assign ld_col  = r_vld ? nxt_col : col;
  assign ld_row  = r_vld ? nxt_row : row;
  assign ld_last = (ld_col == COL_LAST) && (ld_row == ROW_LAST);

  memlcd_pattern_gen #(.CW(CW), .RW(RW)) u_pattern (
    .mode (r_mode),
    .col  (ld_col),
    .row  (ld_row),
    .pix  (pat_pix)
  );

  // A SOF word seen mid-frame is held off (ready low) so it can open the
  // next frame once padding completes.
  always_comb begin
    ready = 1'b0;
    case (state)
      ST_IDLE:   ready = (mode_in == MODE_STREAM) && can_load;
      ST_STREAM: ready = can_load && !s_if.i_s_sof;
      default:   ready = 1'b0;
    endcase
    if (i_reset) ready = 1'b0;
  end

  assign s_if.o_s_ready = ready;
  assign host_acc       = s_if.i_s_valid && ready;
  assign early_sof      = (state == ST_STREAM) && s_if.i_s_valid && s_if.i_s_sof;

  always_comb begin
    load_en   = 1'b0;
    load_data = 6'h00;
    case (state)
      ST_IDLE: begin
        load_en   = host_acc && s_if.i_s_sof;
        load_data = s_if.i_s_data;
      end
      ST_STREAM: begin
        load_en   = host_acc;
        load_data = s_if.i_s_data;
      end
      ST_PAD: begin
        load_en   = can_load;
        load_data = 6'h00;
      end
      default: begin
        load_en   = can_load;
        load_data = pat_pix;
      end
    endcase
  end

  // Stage boundary: FSM, counters and one-entry output register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= ST_IDLE;
      r_mode      <= MODE_STREAM;
      col         <= '0;
      row         <= '0;
      r_vld       <= 1'b0;
      r_data      <= 6'h00;
      o_err_early <= 1'b0;
      o_err_drop  <= 1'b0;
    end else begin
      o_err_early <= 1'b0;
      o_err_drop  <= 1'b0;

      if (o_winc) begin
        col <= nxt_col;
        row <= nxt_row;
      end

      if (load_en) begin
        r_vld  <= 1'b1;
        r_data <= load_data;
      end else if (o_winc) begin
        r_vld <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          r_mode <= mode_in;
          if (mode_in != MODE_STREAM) begin
            state <= ST_PATTERN;
          end else if (host_acc) begin
            if (!s_if.i_s_sof)  o_err_drop <= 1'b1;
            else if (!ld_last)  state <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (early_sof) begin
            o_err_early <= 1'b1;
            state       <= ST_PAD;
          end else if (host_acc && ld_last) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          if (can_load && ld_last) state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memlcd_frame_writer.sv
// Scoreboard bench for memlcd_frame_writer with a reduced frame
// (120 words x 10 lines). Stimulus pushes expected FIFO words into a
// queue; a monitor on the falling edge pops and compares every write.
module tb_memlcd_frame_writer;
  import memlcd_pkg::*;

  localparam int DW = 8;
  localparam int HW = 120;
  localparam int VL = 10;
  localparam int FW = HW * VL;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    mode = 2'b00;
  logic          wfull = 1'b0;
  logic          winc, fdone, eearly, edrop;
  logic [DW-1:0] wdata;

  memlcd_stream_if s_if();

  memlcd_frame_writer #(.DATA_WIDTH(DW), .H_WORDS(HW), .V_LINES(VL)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_mode       (mode),
    .s_if         (s_if),
    .o_winc       (winc),
    .o_wdata      (wdata),
    .i_wfull      (wfull),
    .o_frame_done (fdone),
    .o_err_early  (eearly),
    .o_err_drop   (edrop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] d;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk = 0, n_pass = 0;
  int   exp_idx = 0, wr_cnt = 0, drop_cnt = 0, early_cnt = 0;
  bit   bp_en = 1'b0;
  logic [5:0] bar_pal [8] = '{6'h00, 6'h03, 6'h0C, 6'h0F, 6'h30, 6'h33, 6'h3C, 6'h3F};

  task automatic finish_run();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  task automatic timeout_fail(input string what);
    n_chk++;
    $display("FAIL timeout_%s: bound expired, required completion (t=%0t)", what, $time);
    finish_run();
  endtask

  // Monitor: every FIFO write is checked against the head of the queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (edrop)  drop_cnt++;
      if (eearly) early_cnt++;
      if (winc) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_write: got wdata 0x%0h, required no write", wdata);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wdata", 32'(wdata), 32'(mon_e.d));
          chk("frame_done", 32'(fdone), 32'(mon_e.fd));
        end
      end else begin
        chk("frame_done_idle", 32'(fdone), 32'd0);
      end
    end
  end

  // Random FIFO-full generator for the backpressure phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) wfull = 1'($urandom_range(0, 1));
      else       wfull = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    timeout_fail("watchdog");
  end

  function automatic logic [5:0] gen(input int seed, input int i);
    return 6'((i * 5 + seed * 11 + i / 64) & 63);
  endfunction

  task automatic push_exp(input logic [5:0] d);
    exp_t e;
    e.d  = d;
    e.fd = ((exp_idx % FW) == FW - 1);
    exp_idx++;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [5:0] d, input logic sof);
    int t;
    bit acc;
    t   = 0;
    acc = 1'b0;
    s_if.i_s_valid = 1'b1;
    s_if.i_s_data  = d;
    s_if.i_s_sof   = sof;
    while (!acc) begin
      @(negedge clk);
      acc = s_if.o_s_ready;
      @(posedge clk);
      #1;
      t++;
      if (!acc && t > 4000) timeout_fail("send");
    end
    s_if.i_s_valid = 1'b0;
    s_if.i_s_sof   = 1'b0;
    s_if.i_s_data  = 6'h00;
  endtask

  task automatic send_frame(input int seed);
    logic [5:0] d;
    for (int i = 0; i < FW; i++) begin
      d = gen(seed, i);
      push_exp(d);
      send(d, (i == 0));
    end
  endtask

  task automatic wait_drain(input string what);
    int t;
    t = 0;
    while (exp_q.size() != 0) begin
      @(posedge clk);
      #1;
      t++;
      if (t > 6000) timeout_fail(what);
    end
    repeat (4) @(posedge clk);
    #1;
    chk({what, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_writes(input int n);
    int t;
    t = 0;
    while (wr_cnt < n) begin
      @(posedge clk);
      #1;
      t++;
      if (t > 6000) timeout_fail("writes");
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_winc"},   32'(winc),           32'd0);
    chk({tag, "_ready"},  32'(s_if.o_s_ready), 32'd0);
    chk({tag, "_wdata"},  32'(wdata),          32'd0);
    chk({tag, "_fdone"},  32'(fdone),          32'd0);
    chk({tag, "_early"},  32'(eearly),         32'd0);
    chk({tag, "_drop"},   32'(edrop),          32'd0);
  endtask

  initial begin
    int         base, drops;
    logic [5:0] d;
    int         r, c;

    s_if.i_s_valid = 1'b0;
    s_if.i_s_data  = 6'h00;
    s_if.i_s_sof   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst = 1'b0;

    // Clean stream: two back-to-back frames.
    send_frame(0);
    send_frame(1);
    wait_drain("clean");
    chk("clean_writes", 32'(wr_cnt), 32'(2 * FW));
    chk("clean_drops", 32'(drop_cnt), 32'd0);
    chk("clean_early", 32'(early_cnt), 32'd0);

    // Leading garbage before SOF.
    for (int i = 0; i < 5; i++) send(6'(6'h15 + i), 1'b0);
    send_frame(2);
    wait_drain("garbage");
    chk("garbage_drops", 32'(drop_cnt), 32'd5);
    chk("garbage_writes", 32'(wr_cnt), 32'(3 * FW));

    // Early SOF at word 1000: remainder padded with zeros.
    for (int i = 0; i < 1000; i++) begin
      d = gen(3, i);
      push_exp(d);
      send(d, (i == 0));
    end
    for (int i = 0; i < FW - 1000; i++) push_exp(6'h00);
    push_exp(6'h2A);
    send(6'h2A, 1'b1);
    for (int i = 1; i < FW; i++) begin
      d = gen(4, i);
      push_exp(d);
      send(d, 1'b0);
    end
    wait_drain("early");
    chk("early_count", 32'(early_cnt), 32'd1);
    chk("early_writes", 32'(wr_cnt), 32'(5 * FW));

    // Backpressure: same data as the first clean frame.
    bp_en = 1'b1;
    send_frame(0);
    wait_drain("backpressure");
    bp_en = 1'b0;
    @(posedge clk);
    #2;
    chk("bp_writes", 32'(wr_cnt), 32'(6 * FW));

    // Patterns: bars, then checkerboard, then solid; each switch mid-frame.
    base = wr_cnt;
    for (int i = 0; i < FW; i++) push_exp(bar_pal[(i % HW) / 15]);
    mode = 2'b01;
    wait_writes(base + FW / 2);
    mode = 2'b10;
    for (int i = 0; i < FW; i++) begin
      r = i / HW;
      c = i % HW;
      push_exp((((c >> 3) ^ (r >> 3)) & 1) != 0 ? 6'h3F : 6'h00);
    end
    wait_writes(base + FW + FW / 2);
    mode = 2'b11;
    for (int i = 0; i < FW; i++) push_exp(6'h00);
    wait_writes(base + 2 * FW + FW / 2);
    mode = 2'b00;
    wait_drain("patterns");
    repeat (20) @(posedge clk);
    #1;
    chk("pattern_writes", 32'(wr_cnt), 32'(base + 3 * FW));

    // Reset mid-frame, then the block must wait for SOF.
    for (int i = 0; i < 300; i++) begin
      d = gen(5, i);
      push_exp(d);
      send(d, (i == 0));
    end
    rst = 1'b1;
    #1;
    chk_outputs_zero("midreset");
    exp_q.delete();
    exp_idx = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    base  = wr_cnt;
    drops = drop_cnt;
    for (int i = 0; i < 3; i++) send(6'(6'h0A + i), 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("post_reset_no_write", 32'(wr_cnt), 32'(base));
    chk("post_reset_drops", 32'(drop_cnt), 32'(drops + 3));
    send_frame(6);
    wait_drain("post_reset");
    chk("post_reset_writes", 32'(wr_cnt), 32'(base + FW));
    chk("final_early", 32'(early_cnt), 32'd1);

    finish_run();
  end

endmodule

// File: doc/memlcd_frame_writer.md
# memlcd_frame_writer

Write-side producer for the memory-LCD pixel FIFO. It accepts a host pixel stream with start-of-frame marking, or generates bring-up test patterns, and pushes exactly one frame of `H_WORDS × V_LINES` words per frame into the FIFO write port. The LCD timing FSM drains the other side of that FIFO. The block keeps frame alignment so that the FIFO always carries whole, correctly ordered frames, even when the host stream misbehaves.

## Interface
- `DATA_WIDTH`, 8: FIFO word width; must be ≥ 6.
- `H_WORDS`, 120: words per line.
- `V_LINES`, 640: lines per frame.
- `i_clk  in  1`: clock. One clock domain; this is the FIFO write clock.
- `i_reset  in  1`: asynchronous, active-high reset.
- `i_mode  in  2`: 00 stream, 01 colour bars, 10 checkerboard, 11 solid black.
- `i_s_valid  in  1`: host word valid.
- `i_s_data  in  6`: host pixel, RGB 2:2:2.
- `i_s_sof  in  1`: marks the host word as pixel (0,0) of a frame.
- `o_s_ready  out  1`: host word accepted when `i_s_valid && o_s_ready`.
- `o_winc  out  1`: FIFO write strobe.
- `o_wdata  out  DATA_WIDTH`: FIFO write data; bits [DATA_WIDTH-1:6] are always 0.
- `i_wfull  in  1`: FIFO full, from the write-clock domain.
- `o_frame_done  out  1`: one-cycle pulse when the last word of a frame is written.
- `o_err_early  out  1`: one-cycle pulse on an early SOF (SOF seen mid-frame).
- `o_err_drop  out  1`: one-cycle pulse for each non-SOF word discarded while waiting for SOF.

## Operation
- **Counters**
  - `col` runs 0..H_WORDS-1; `row` runs 0..V_LINES-1.
  - Both advance only when a word is written (`o_winc`).
  - `col` wraps to 0 and increments `row`. At (V_LINES-1, H_WORDS-1) both wrap to 0.
- **Output stage**
  - One-entry register: `r_vld` plus data.
  - `o_winc = r_vld && !i_wfull`. This is the only combinational path, and it is from `i_wfull`.
  - The register loads when `!r_vld || o_winc`.
- **IDLE**
  - Counters are 0. `i_mode` is latched here only; a mode change mid-frame takes effect at the next frame.
  - Stream mode: `o_s_ready=1`.
    - A word with `sof=1` is loaded as pixel (0,0) and the FSM goes to STREAM.
    - A word with `sof=0` is discarded and pulses `o_err_drop`.
  - Pattern modes go directly to PATTERN.
- **STREAM**
  - `o_s_ready` is high when the output register can load.
  - Each accepted word is written in order.
  - Accepted word with `sof=1` at a position other than (0,0): the word is not consumed (`o_s_ready` drops that cycle), `o_err_early` pulses, and the FSM goes to PAD.
  - After the last word of a frame, go to IDLE.
- **PAD**
  - `o_s_ready=0`. Write zeros until the frame completes, then go to IDLE.
  - The held SOF word is then accepted as pixel (0,0) of the next frame.
- **PATTERN**
  - `o_s_ready=0`. Load one pattern word per available slot.
  - Colour bars: `wdata = bar(col/15)`, with bars 0..7 = 00,03,0C,0F,30,33,3C,3F.
  - Checkerboard: `(col[3]^row[3]) ? 6'h3F : 6'h00`.
  - Solid: 00.
  - Return to IDLE after the last word, so the mode is re-latched every frame.
- **Frame done:** `o_frame_done` is asserted together with `o_winc` for the write at (V_LINES-1, H_WORDS-1).
- **FIFO full:** while `i_wfull` is high, the data is held, no counter moves, and no words are lost.
- **Reset:**
  - All outputs 0 (`o_s_ready=0`), state IDLE, counters 0, `r_vld=0`.
  - Reset mid-frame abandons the partial frame. The downstream FIFO and FSM are reset together with this block.

## Timing
- **Latency:** a word accepted at cycle N drives `o_winc`/`o_wdata` at N+1 if `!i_wfull`.
- **Throughput:** 1 word/clk sustained.
- **Frame length:** exactly H_WORDS·V_LINES writes per frame in every mode, 76800 at the defaults.
- **PAD:** writes 1 word/clk when not full.
- **Early-SOF cycle:** `o_s_ready=0`. Acceptance of the SOF word resumes at the earliest one cycle after the last PAD write.
- **Simultaneous SOF and last-word position:** this is a legal frame end, not an early SOF.

## Structure
- Package `memlcd_pkg` holds:
  - `H_WORDS` and `V_LINES` defaults;
  - mode encodings (`MODE_STREAM`, `MODE_BARS`, `MODE_CHECK`, `MODE_SOLID`);
  - state encoding (IDLE, STREAM, PAD, PATTERN);
  - the colour-bar palette.
- Sub-module `memlcd_pattern_gen` is combinational: `mode`, `col`, `row` → 6-bit pixel.
- The FSM, counters and output register stay in `memlcd_frame_writer`.

## Test plan
- **Clean stream:** 2 frames of 76800 words, SOF on the first word of each, `i_wfull=0`.
  - Expect 153600 writes in order.
  - `o_frame_done` pulses at writes 76800 and 153600; no error pulses.
- **Leading garbage:** 5 words with `sof=0` sent before SOF.
  - Expect 5 `o_err_drop` pulses; the first write carries the SOF word's data.
- **Early SOF:** SOF sent at word 1000 of a frame.
  - Expect an `o_err_early` pulse and 75800 zero writes.
  - Next, the SOF word is written as word 0 of the following frame.
- **Backpressure:** `i_wfull` toggled randomly 50% during a frame.
  - Write data sequence is identical to the unstalled case; no loss or duplication.
- **Patterns:**
  - Mode 01: the word at col 16 is 03 and the word at col 119 is 3F.
  - Mode 10: (row 0, col 8) is 3F and (row 8, col 8) is 00.
  - Switching the mode mid-frame changes the pattern only from the next frame.
- **Reset:** `i_reset` asserted mid-frame at word 3000.
  - Outputs go to 0 immediately; after release the block waits in IDLE for SOF.
